// File: rtl/fp16_classify_pkg.sv
// fp16_classify_pkg: shared binary16 field constants, operand struct and class enum.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp16_classify_pkg;

  localparam int EXP_W     = 5;
  localparam int MAN_W     = 10;
  localparam int QUIET_BIT = 9;
  localparam int NUM_CLASS = 10;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  // Enum value is the bit position in the one-hot class vector. The order puts
  // snan in the MSB, so the vector reads in the same order as the output ports.
  typedef enum logic [3:0] {
    CLS_POS_INF      = 4'd0,
    CLS_POS_NORMAL   = 4'd1,
    CLS_POS_DENORMAL = 4'd2,
    CLS_POS_ZERO     = 4'd3,
    CLS_NEG_ZERO     = 4'd4,
    CLS_NEG_DENORMAL = 4'd5,
    CLS_NEG_NORMAL   = 4'd6,
    CLS_NEG_INF      = 4'd7,
    CLS_QNAN         = 4'd8,
    CLS_SNAN         = 4'd9
  } fp16_class_e;

endpackage

// File: rtl/fp16_field_decode.sv
// fp16_field_decode: splits a binary16 word into the terms the classifier needs.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; there is no handshake.
//
// Ports:
//   word_i          16-bit binary16 operand
//   sign_o          sign bit
//   exp_all_ones_o  exponent == 5'h1F (inf/NaN)
//   exp_zero_o      exponent == 0 (zero/denormal)
//   man_zero_o      mantissa == 0
//   man_msb_o       mantissa quiet bit (bit 9)
module fp16_field_decode
  import fp16_classify_pkg::*;
(
  input  logic [15:0] word_i,
  output logic        sign_o,
  output logic        exp_all_ones_o,
  output logic        exp_zero_o,
  output logic        man_zero_o,
  output logic        man_msb_o
);

  fp16_t op;

  assign op             = fp16_t'(word_i);
  assign sign_o         = op.sign;
  assign exp_all_ones_o = (op.exp == EXP_MAX);
  assign exp_zero_o     = (op.exp == '0);
  assign man_zero_o     = (op.man == '0);
  assign man_msb_o      = op.man[QUIET_BIT];

endmodule

// File: rtl/fp16_classify.sv
// fp16_classify: one-hot IEEE 754 binary16 classifier (fclass-style, ten classes).
// Latency: 0 cycles; 1 cycle with FP16_CLASSIFY_REG_OUT_EN defined.
// Backpressure: none; a new operand is accepted every cycle.
//
// Ports:
//   clk, rst_n      clock and async active-low reset; only used by the output register
//   in              binary16 operand
//   is_*            ten class flags, exactly one set (all clear while in reset
//                   when the output register is present)
//
// Build option: define FP16_CLASSIFY_REG_OUT_EN to register the flags.
module fp16_classify
  import fp16_classify_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  output logic        is_snan,
  output logic        is_qnan,
  output logic        is_neg_inf,
  output logic        is_neg_normal,
  output logic        is_neg_denormal,
  output logic        is_neg_zero,
  output logic        is_pos_zero,
  output logic        is_pos_denormal,
  output logic        is_pos_normal,
  output logic        is_pos_inf
);

  logic sign;
  logic exp_all_ones;
  logic exp_zero;
  logic man_zero;
  logic man_msb;

  logic                 is_nan;
  logic                 is_inf;
  logic                 is_zero;
  logic                 is_den;
  logic                 is_norm;
  logic [NUM_CLASS-1:0] cls_d;
  logic [NUM_CLASS-1:0] cls_o;

  fp16_field_decode u_decode (
    .word_i         (in),
    .sign_o         (sign),
    .exp_all_ones_o (exp_all_ones),
    .exp_zero_o     (exp_zero),
    .man_zero_o     (man_zero),
    .man_msb_o      (man_msb)
  );

  // Exponent/mantissa split into five mutually exclusive categories; the sign
  // then picks the half, except for NaNs where it is ignored.
  assign is_nan  = exp_all_ones & ~man_zero;
  assign is_inf  = exp_all_ones &  man_zero;
  assign is_zero = exp_zero     &  man_zero;
  assign is_den  = exp_zero     & ~man_zero;
  assign is_norm = ~exp_all_ones & ~exp_zero;

  always_comb begin
    cls_d                   = '0;
    cls_d[CLS_SNAN]         = is_nan & ~man_msb;
    cls_d[CLS_QNAN]         = is_nan &  man_msb;
    cls_d[CLS_NEG_INF]      = is_inf  &  sign;
    cls_d[CLS_POS_INF]      = is_inf  & ~sign;
    cls_d[CLS_NEG_NORMAL]   = is_norm &  sign;
    cls_d[CLS_POS_NORMAL]   = is_norm & ~sign;
    cls_d[CLS_NEG_DENORMAL] = is_den  &  sign;
    cls_d[CLS_POS_DENORMAL] = is_den  & ~sign;
    cls_d[CLS_NEG_ZERO]     = is_zero &  sign;
    cls_d[CLS_POS_ZERO]     = is_zero & ~sign;
  end

`ifdef FP16_CLASSIFY_REG_OUT_EN
  logic [NUM_CLASS-1:0] cls_q;

  // Reset clears all flags at once; no in-flight result survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q <= '0;
    end else begin
      cls_q <= cls_d;
    end
  end

  assign cls_o = cls_q;
`else
  // Clock and reset are not needed without the output register.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign cls_o = cls_d;
`endif

  assign is_snan         = cls_o[CLS_SNAN];
  assign is_qnan         = cls_o[CLS_QNAN];
  assign is_neg_inf      = cls_o[CLS_NEG_INF];
  assign is_neg_normal   = cls_o[CLS_NEG_NORMAL];
  assign is_neg_denormal = cls_o[CLS_NEG_DENORMAL];
  assign is_neg_zero     = cls_o[CLS_NEG_ZERO];
  assign is_pos_zero     = cls_o[CLS_POS_ZERO];
  assign is_pos_denormal = cls_o[CLS_POS_DENORMAL];
  assign is_pos_normal   = cls_o[CLS_POS_NORMAL];
  assign is_pos_inf      = cls_o[CLS_POS_INF];

endmodule

// File: tb/tb_fp16_classify.sv
// tb_fp16_classify: scoreboard bench for fp16_classify, default or registered build.
// Latency: follows the DUT build (0 or 1 cycle).
// Backpressure: none.
module tb_fp16_classify;

  // Flag vector order: {snan, qnan, neg_inf, neg_normal, neg_denormal,
  //                     neg_zero, pos_zero, pos_denormal, pos_normal, pos_inf}
  localparam logic [9:0] F_SNAN  = 10'b10_0000_0000;
  localparam logic [9:0] F_QNAN  = 10'b01_0000_0000;
  localparam logic [9:0] F_NINF  = 10'b00_1000_0000;
  localparam logic [9:0] F_NNORM = 10'b00_0100_0000;
  localparam logic [9:0] F_NDEN  = 10'b00_0010_0000;
  localparam logic [9:0] F_NZERO = 10'b00_0001_0000;
  localparam logic [9:0] F_PZERO = 10'b00_0000_1000;
  localparam logic [9:0] F_PDEN  = 10'b00_0000_0100;
  localparam logic [9:0] F_PNORM = 10'b00_0000_0010;
  localparam logic [9:0] F_PINF  = 10'b00_0000_0001;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic is_snan, is_qnan, is_neg_inf, is_neg_normal, is_neg_denormal;
  logic is_neg_zero, is_pos_zero, is_pos_denormal, is_pos_normal, is_pos_inf;

  int n_checks;
  int n_errors;

  logic [9:0]  exp_q[$];
  logic [15:0] op_q[$];

  fp16_classify dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in              (in),
    .is_snan         (is_snan),
    .is_qnan         (is_qnan),
    .is_neg_inf      (is_neg_inf),
    .is_neg_normal   (is_neg_normal),
    .is_neg_denormal (is_neg_denormal),
    .is_neg_zero     (is_neg_zero),
    .is_pos_zero     (is_pos_zero),
    .is_pos_denormal (is_pos_denormal),
    .is_pos_normal   (is_pos_normal),
    .is_pos_inf      (is_pos_inf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [9:0] flags();
    return {is_snan, is_qnan, is_neg_inf, is_neg_normal, is_neg_denormal,
            is_neg_zero, is_pos_zero, is_pos_denormal, is_pos_normal, is_pos_inf};
  endfunction

  // Reference model written from the numeric definition of each class.
  function automatic logic [9:0] ref_class(input logic [15:0] v);
    int  e;
    int  m;
    bit  neg;
    e   = int'(v[14:10]);
    m   = int'(v[9:0]);
    neg = v[15];
    if (e == 31) begin
      if (m == 0)        return neg ? F_NINF : F_PINF;
      else if (m >= 512) return F_QNAN;
      else               return F_SNAN;
    end
    if (e == 0) begin
      if (m == 0) return neg ? F_NZERO : F_PZERO;
      return neg ? F_NDEN : F_PDEN;
    end
    return neg ? F_NNORM : F_PNORM;
  endfunction

  task automatic check_val(input string tag, input logic [15:0] op,
                           input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s in=%04h got=%b expected=%b", tag, op, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the flags now on the outputs.
  task automatic pop_check(input string tag);
    logic [9:0]  e;
    logic [15:0] op;
    logic [9:0]  got;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s scoreboard empty got=%b expected=entry", tag, flags());
      return;
    end
    e   = exp_q.pop_front();
    op  = op_q.pop_front();
    got = flags();
    check_val(tag, op, got, e);
    if ($countones(got) != 1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_onehot in=%04h got=%b expected=one-hot", tag, op, got);
    end
  endtask

  task automatic push(input logic [15:0] v, input logic [9:0] e);
    in = v;
    exp_q.push_back(e);
    op_q.push_back(v);
  endtask

  // Drive one operand and check its result after the build's latency.
  task automatic step(input string tag, input logic [15:0] v, input logic [9:0] e);
    push(v, e);
`ifdef FP16_CLASSIFY_REG_OUT_EN
    @(posedge clk);
`endif
    #1;
    pop_check(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in       = 16'h0000;
    #1;

`ifdef FP16_CLASSIFY_REG_OUT_EN
    check_val("reset_state", in, flags(), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`else
    check_val("reset_state", in, flags(), F_PZERO);
    rst_n = 1'b1;
    #1;
    check_val("rst_no_effect", in, flags(), F_PZERO);
`endif

    // Directed points from the classification table.
    step("snan_pos",   16'h7C01, F_SNAN);
    step("snan_neg",   16'hFC01, F_SNAN);
    step("snan_max",   16'h7DFF, F_SNAN);
    step("qnan_pos",   16'h7E00, F_QNAN);
    step("qnan_neg",   16'hFFFF, F_QNAN);
    step("pos_inf",    16'h7C00, F_PINF);
    step("neg_inf",    16'hFC00, F_NINF);
    step("pos_zero",   16'h0000, F_PZERO);
    step("neg_zero",   16'h8000, F_NZERO);
    step("pos_den",    16'h0001, F_PDEN);
    step("neg_den",    16'h83FF, F_NDEN);
    step("min_norm",   16'h0400, F_PNORM);
    step("max_norm",   16'h7BFF, F_PNORM);
    step("one",        16'h3C00, F_PNORM);
    step("minus_two",  16'hC000, F_NNORM);
    step("neg_minnorm",16'h8400, F_NNORM);

`ifdef FP16_CLASSIFY_REG_OUT_EN
    // Back-to-back operands: results emerge on three consecutive cycles.
    push(16'h7C00, F_PINF);
    @(posedge clk); #1; pop_check("b2b_inf");
    push(16'h0001, F_PDEN);
    @(posedge clk); #1; pop_check("b2b_den");
    push(16'h7E00, F_QNAN);
    @(posedge clk); #1; pop_check("b2b_qnan");

    // Mid-stream reset: flags clear with no clock edge, pending result dropped.
    push(16'hC000, F_NNORM);
    @(posedge clk); #1;
    in = 16'h7C01;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset", in, flags(), 10'b0);
    exp_q.delete();
    op_q.delete();
    @(posedge clk); #1;
    check_val("reset_held", in, flags(), 10'b0);
    in = 16'h3C00;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(F_PNORM);
    op_q.push_back(in);
    @(posedge clk); #1;
    pop_check("reset_release");

    // Strided sweep keeps the cycle count low in the clocked build.
    for (int v = 0; v < 65536; v += 7) begin
      step("sweep", 16'(v), ref_class(16'(v)));
    end
    step("sweep_last", 16'hFFFE, ref_class(16'hFFFE));
`else
    // Reset toggles must not disturb combinational outputs.
    in = 16'hC000;
    rst_n = 1'b0;
    #1;
    check_val("rst_low_comb", in, flags(), F_NNORM);
    rst_n = 1'b1;

    for (int v = 0; v < 65536; v++) begin
      step("sweep", 16'(v), ref_class(16'(v)));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
